// File: rtl/apb_fpu_pkg.sv
// Shared constants for the APB FPU sequencer: register offsets, field widths,
// STATUS bit positions and the sequencer state encoding.
package apb_fpu_pkg;
  localparam int OPSEL_W = 4;
  localparam int FLAGS_W = 5;

  localparam logic [7:0] OFFS_OP_A   = 8'h00;
  localparam logic [7:0] OFFS_OP_B   = 8'h04;
  localparam logic [7:0] OFFS_CTRL   = 8'h08;
  localparam logic [7:0] OFFS_RESULT = 8'h0C;
  localparam logic [7:0] OFFS_STATUS = 8'h10;

  localparam int ST_BUSY      = 0;
  localparam int ST_VALID     = 1;
  localparam int ST_TIMEOUT   = 2;
  localparam int ST_FLAGS_LSB = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } seq_state_e;
endpackage

// File: rtl/fpu_seq_timer.sv
// Saturating watchdog counter: clear has priority over enable, tc_o is high
// once the count reaches TIMEOUT_CYCLES-1, and the count holds there.
module fpu_seq_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);
endmodule

// File: rtl/apb_fpu_seq.sv
// APB3 slave that launches one FPU operation per CTRL write and latches its result.
// Optional completion interrupt is built when APB_FPU_SEQ_IRQ_EN is defined.
module apb_fpu_seq
  import apb_fpu_pkg::*;
#(
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1A108000,
  parameter int                        TIMEOUT_CYCLES = 64
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [31:0]               fpu_op_a,
  output logic [31:0]               fpu_op_b,
  output logic [OPSEL_W-1:0]        fpu_opsel,
  output logic                      fpu_start,
  input  logic                      fpu_done,
  input  logic [31:0]               fpu_result,
  input  logic [FLAGS_W-1:0]        fpu_flags,
  output logic                      irq_o
);
  seq_state_e         state_q, state_d;
  logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [OPSEL_W-1:0] opsel_q, opsel_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic               valid_q, valid_d, timeout_q, timeout_d;

  logic [APB_ADDR_WIDTH-1:0] off;
  logic sel_op_a, sel_op_b, sel_ctrl, sel_result, sel_status, sel_rw;
  logic busy, acc_phase, wr_acc, rd_acc, launch, finish, tc;

  assign off        = PADDR - BASE_ADDR;
  assign sel_op_a   = (off == APB_ADDR_WIDTH'(OFFS_OP_A));
  assign sel_op_b   = (off == APB_ADDR_WIDTH'(OFFS_OP_B));
  assign sel_ctrl   = (off == APB_ADDR_WIDTH'(OFFS_CTRL));
  assign sel_result = (off == APB_ADDR_WIDTH'(OFFS_RESULT));
  assign sel_status = (off == APB_ADDR_WIDTH'(OFFS_STATUS));
  assign sel_rw     = sel_op_a | sel_op_b | sel_ctrl;

  assign busy      = (state_q != S_IDLE);
  assign acc_phase = PSEL & PENABLE;
  // Only a RESULT read can stall, and only while an operation is outstanding.
  assign PREADY    = ~(acc_phase & ~PWRITE & sel_result & busy);
  assign wr_acc    = acc_phase & PREADY & PWRITE;
  assign rd_acc    = acc_phase & PREADY & ~PWRITE;
  assign launch    = wr_acc & sel_ctrl & ~busy;
  assign finish    = (state_q == S_WAIT) & (fpu_done | tc);

  assign fpu_op_a  = op_a_q;
  assign fpu_op_b  = op_b_q;
  assign fpu_opsel = opsel_q;
  assign fpu_start = (state_q == S_ISSUE);

  fpu_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (CLK),
    .rst_n(RSTN),
    .clr_i(state_q == S_ISSUE),
    .en_i (state_q == S_WAIT),
    .tc_o (tc)
  );

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    opsel_d   = opsel_q;
    result_d  = result_q;
    flags_d   = flags_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    PRDATA    = '0;
    PSLVERR   = 1'b0;

    if (wr_acc) begin
      if (!sel_rw || busy) begin
        PSLVERR = 1'b1;
      end else begin
        if (sel_op_a) op_a_d = PWDATA;
        if (sel_op_b) op_b_d = PWDATA;
      end
    end
    if (launch) begin
      opsel_d   = PWDATA[OPSEL_W-1:0];
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      state_d   = S_ISSUE;
    end

    if (rd_acc) begin
      if (sel_op_a) begin
        PRDATA = op_a_q;
      end else if (sel_op_b) begin
        PRDATA = op_b_q;
      end else if (sel_ctrl) begin
        PRDATA[OPSEL_W-1:0] = opsel_q;
      end else if (sel_result) begin
        PRDATA  = result_q;
        PSLVERR = timeout_q;
      end else if (sel_status) begin
        PRDATA[ST_BUSY]                    = busy;
        PRDATA[ST_VALID]                   = valid_q;
        PRDATA[ST_TIMEOUT]                 = timeout_q;
        PRDATA[ST_FLAGS_LSB +: FLAGS_W]    = flags_q;
      end else begin
        PSLVERR = 1'b1;
      end
    end

    case (state_q)
      S_IDLE:  ;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (fpu_done) begin
          result_d = fpu_result;
          flags_d  = fpu_flags;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end else if (tc) begin
          result_d  = '0;
          flags_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      opsel_q   <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      opsel_q   <= opsel_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef APB_FPU_SEQ_IRQ_EN
  logic irq_q, irq_d;

  // Completion wins over a same-cycle clear.
  always_comb begin
    irq_d = irq_q;
    if (launch || (rd_acc && sel_result)) irq_d = 1'b0;
    if (finish) irq_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_finish;
  assign unused_finish = finish;
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_apb_fpu_seq.sv
// Scoreboard bench for apb_fpu_seq: APB expectations are queued when a transfer
// is driven and popped when it completes; a small FPU model answers fpu_start.
module tb_apb_fpu_seq;
  localparam logic [31:0] BASE = 32'h1A108000;
`ifdef APB_FPU_SEQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_result;
  logic [3:0]  fpu_opsel;
  logic        fpu_start, fpu_done, irq_o;
  logic [4:0]  fpu_flags;

  apb_fpu_seq dut (
    .CLK(CLK), .RSTN(RSTN), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
    .fpu_opsel(fpu_opsel), .fpu_start(fpu_start), .fpu_done(fpu_done),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags), .irq_o(irq_o)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // FPU model: fpu_lat==0 means the operation never completes.
  int          fpu_lat = 5;
  int          cnt_down = 0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_flags = '0;

  initial begin
    fpu_done   = 1'b0;
    fpu_result = 32'hDEADBEEF;
    fpu_flags  = 5'h1F;
    forever begin
      @(negedge CLK);
      fpu_done   = 1'b0;
      fpu_result = 32'hDEADBEEF;
      fpu_flags  = 5'h1F;
      if (!RSTN) begin
        cnt_down = 0;
      end else begin
        if (cnt_down > 0) begin
          cnt_down--;
          if (cnt_down == 0) begin
            fpu_done   = 1'b1;
            fpu_result = m_res;
            fpu_flags  = m_flags;
          end
        end
        if (fpu_start) begin
          start_cnt++;
          start_cyc = cyc;
          if (fpu_lat > 0) cnt_down = fpu_lat;
        end
      end
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int          last_stalls = 0;
  int          acc_cyc = 0;
  logic [31:0] cap_data;
  logic        cap_err;

  task automatic apb_xfer(input bit wr, input logic [7:0] off, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err, input string tag);
    exp_t e;
    int   n;
    e.tag = tag; e.data = exp_data; e.err = exp_err;
    sb_q.push_back(e);
    @(negedge CLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = BASE + {24'b0, off}; PWDATA = wdata;
    @(negedge CLK);
    PENABLE = 1'b1;
    #1;
    n = 0;
    while (!PREADY && n < 500) begin
      @(negedge CLK);
      #1;
      n++;
    end
    last_stalls = n;
    check({tag, "_ready"}, {31'b0, PREADY}, 32'h1);
    cap_data = PRDATA;
    cap_err  = PSLVERR;
    @(posedge CLK);
    acc_cyc = cyc;
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    e = sb_q.pop_front();
    check({e.tag, "_data"}, cap_data, e.data);
    check({e.tag, "_err"}, {31'b0, cap_err}, {31'b0, e.err});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int s0;

  initial begin
    RSTN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_pready", {31'b0, PREADY}, 32'h1);
    check("rst_start", {31'b0, fpu_start}, 32'h0);
    check("rst_irq", {31'b0, irq_o}, 32'h0);
    check("rst_slverr", {31'b0, PSLVERR}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    apb_xfer(0, 8'h10, 0, 32'h0, 0, "rst_status");
    apb_xfer(0, 8'h0C, 0, 32'h0, 0, "rst_result");
    apb_xfer(0, 8'h00, 0, 32'h0, 0, "rst_op_a");

    // basic add, done after 5 cycles
    m_res = 32'h40400000; m_flags = 5'h0; fpu_lat = 5; s0 = start_cnt;
    apb_xfer(1, 8'h00, 32'h3F800000, 32'h0, 0, "wr_op_a");
    apb_xfer(1, 8'h04, 32'h40000000, 32'h0, 0, "wr_op_b");
    apb_xfer(1, 8'h08, 32'h00000001, 32'h0, 0, "wr_ctrl");
    repeat (3) @(negedge CLK);
    check("start_latency", start_cyc, acc_cyc + 1);
    check("drv_op_a", fpu_op_a, 32'h3F800000);
    check("drv_op_b", fpu_op_b, 32'h40000000);
    check("drv_opsel", {28'b0, fpu_opsel}, 32'h1);
    apb_xfer(0, 8'h10, 0, 32'h1, 0, "status_busy");
    repeat (10) @(negedge CLK);
    #1;
    check("irq_set_done", {31'b0, irq_o}, {31'b0, IRQ_ON});
    check("start_single", start_cnt - s0, 1);
    apb_xfer(0, 8'h10, 0, 32'h2, 0, "status_valid");
    apb_xfer(0, 8'h0C, 0, 32'h40400000, 0, "result_add");
    check("irq_clr_read", {31'b0, irq_o}, 32'h0);
    apb_xfer(0, 8'h08, 0, 32'h1, 0, "rd_ctrl");

    // stalled RESULT read, done after 10 cycles, NX flag
    m_res = 32'h40A00000; m_flags = 5'h01; fpu_lat = 10;
    apb_xfer(1, 8'h08, 32'h2, 32'h0, 0, "wr_ctrl2");
    apb_xfer(0, 8'h0C, 0, 32'h40A00000, 0, "result_stall");
    check("stall_cycles", last_stalls, 10);
    apb_xfer(0, 8'h10, 0, 32'h0A, 0, "status_flags");

    // timeout: model never answers
    fpu_lat = 0;
    apb_xfer(1, 8'h08, 32'h3, 32'h0, 0, "wr_ctrl_to");
    apb_xfer(0, 8'h0C, 0, 32'h0, 1, "result_timeout");
    check("timeout_stalls", last_stalls, 64);
    apb_xfer(0, 8'h10, 0, 32'h04, 0, "status_timeout");

    // writes while busy are rejected
    m_res = 32'h11111111; m_flags = 5'h0; fpu_lat = 20; s0 = start_cnt;
    apb_xfer(1, 8'h08, 32'h1, 32'h0, 0, "wr_ctrl4");
    apb_xfer(1, 8'h00, 32'h12345678, 32'h0, 1, "wr_busy_op_a");
    apb_xfer(1, 8'h08, 32'h5, 32'h0, 1, "wr_busy_ctrl");
    apb_xfer(0, 8'h0C, 0, 32'h11111111, 0, "result_busy");
    apb_xfer(0, 8'h00, 0, 32'h3F800000, 0, "op_a_kept");
    apb_xfer(0, 8'h08, 0, 32'h1, 0, "ctrl_kept");
    repeat (25) @(negedge CLK);
    check("no_second_start", start_cnt - s0, 1);

    // error responses and idle bus
    apb_xfer(0, 8'h14, 0, 32'h0, 1, "rd_unmapped");
    apb_xfer(1, 8'h0C, 32'hFFFFFFFF, 32'h0, 1, "wr_result");
    apb_xfer(1, 8'h10, 32'hFFFFFFFF, 32'h0, 1, "wr_status");
    apb_xfer(0, 8'h0C, 0, 32'h11111111, 0, "result_kept");
    apb_xfer(0, 8'h10, 0, 32'h2, 0, "status_kept");
    #1;
    check("idle_slverr", {31'b0, PSLVERR}, 32'h0);
    check("idle_prdata", PRDATA, 32'h0);

    // asynchronous reset while the launch pulse is high
    fpu_lat = 0;
    apb_xfer(1, 8'h08, 32'h7, 32'h0, 0, "wr_ctrl_rst");
    check("issue_start", {31'b0, fpu_start}, 32'h1);
    #2;
    RSTN = 1'b0;
    #1;
    check("async_start", {31'b0, fpu_start}, 32'h0);
    check("async_pready", {31'b0, PREADY}, 32'h1);
    check("async_irq", {31'b0, irq_o}, 32'h0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    apb_xfer(0, 8'h00, 0, 32'h0, 0, "post_rst_op_a");
    apb_xfer(0, 8'h04, 0, 32'h0, 0, "post_rst_op_b");
    apb_xfer(0, 8'h08, 0, 32'h0, 0, "post_rst_ctrl");
    apb_xfer(0, 8'h0C, 0, 32'h0, 0, "post_rst_result");
    apb_xfer(0, 8'h10, 0, 32'h0, 0, "post_rst_status");

    m_res = 32'h40400000; m_flags = 5'h0; fpu_lat = 5; s0 = start_cnt;
    apb_xfer(1, 8'h00, 32'h3F800000, 32'h0, 0, "wr_op_a_r");
    apb_xfer(1, 8'h04, 32'h40000000, 32'h0, 0, "wr_op_b_r");
    apb_xfer(1, 8'h08, 32'h1, 32'h0, 0, "wr_ctrl_r");
    repeat (10) @(negedge CLK);
    #1;
    check("irq_set_r", {31'b0, irq_o}, {31'b0, IRQ_ON});
    apb_xfer(0, 8'h0C, 0, 32'h40400000, 0, "result_r");
    check("irq_clr_r", {31'b0, irq_o}, 32'h0);
    check("start_r", start_cnt - s0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_fpu_seq.md
Name: apb_fpu_seq

Overview:
- APB3 slave that sequences the shared FPU core: holds operands and opcode, launches one operation per CTRL write, waits for completion, and latches result and flags.
- Inserts PREADY wait states on RESULT reads while an operation is in flight.
- Aborts hung operations with a timeout.
- Sits between the peripheral APB bus and the FPU datapath, in place of a purely combinational register decode.

Parameters:
- APB_ADDR_WIDTH, 32, APB address width.
- BASE_ADDR, 32'h1A108000, block base address; offsets are decoded relative to it.
- TIMEOUT_CYCLES, 64, number of WAIT cycles without fpu_done before abort; minimum 2.

Ports:
- CLK  in  1  system clock
- RSTN  in  1  asynchronous active-low reset
- PADDR  in  APB_ADDR_WIDTH  APB address
- PWDATA  in  32  APB write data
- PWRITE  in  1  APB write strobe
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready
- PSLVERR  out  1  APB error
- fpu_op_a  out  32  operand A to FPU
- fpu_op_b  out  32  operand B to FPU
- fpu_opsel  out  4  FPU operation select
- fpu_start  out  1  one-cycle launch pulse
- fpu_done  in  1  FPU completion strobe, single cycle
- fpu_result  in  32  FPU result, valid with fpu_done
- fpu_flags  in  5  IEEE flags NV,DZ,OF,UF,NX, valid with fpu_done
- irq_o  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Interface: one clock, CLK; reset RSTN is asynchronous, active-low. All flops clear on RSTN low.
- Reset values:
  - All outputs 0, except PREADY=1.
  - OP_A, OP_B, opsel, RESULT, flags = 0.
  - STATUS.valid = 0, STATUS.timeout = 0. State IDLE.
- Register map (offset from BASE_ADDR):
  - 0x00 OP_A, RW.
  - 0x04 OP_B, RW.
  - 0x08 CTRL, RW: [3:0] opsel. Any write launches an operation.
  - 0x0C RESULT, RO.
  - 0x10 STATUS, RO: [0] busy, [1] valid, [2] timeout, [7:3] flags.
- Access qualification:
  - An access takes effect only in the access phase (PSEL & PENABLE) with PREADY=1.
  - Setup phase has no side effects.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: an accepted CTRL write goes to ISSUE. It clears valid and timeout and latches opsel.
  - ISSUE: fpu_start=1 for exactly one cycle, then go to WAIT and clear the timeout counter.
  - WAIT:
    - On fpu_done: latch fpu_result and fpu_flags, set valid, go to IDLE.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: RESULT=0, flags=0, set timeout, go to IDLE.
  - fpu_done in IDLE or ISSUE is ignored.
- Latency:
  - CTRL write accepted in cycle N gives fpu_start in N+1.
  - fpu_done in cycle M gives RESULT/STATUS readable, and busy=0, from M+1.
- busy = (state != IDLE).
- fpu_op_a, fpu_op_b and fpu_opsel are driven from the registers continuously and held stable from ISSUE through WAIT.
- Writes while busy (any RW register):
  - Complete with PREADY=1 and PSLVERR=1.
  - Register contents are unchanged and no launch occurs.
- RESULT read while busy:
  - PREADY is held 0 until the cycle after completion, then the read completes with the new RESULT.
  - If completion was a timeout, PSLVERR=1 and PRDATA=0.
- STATUS, OP_A, OP_B and CTRL reads never stall.
- Write to RESULT or STATUS: PSLVERR=1, ignored.
- Unmapped offset: PREADY=1, PSLVERR=1, PRDATA=0.
- PSLVERR is valid only when PSEL & PENABLE & PREADY; it is 0 otherwise.
- PRDATA is 0 when not in a read access phase.
- RSTN asserted mid-operation: immediate return to IDLE; fpu_start deasserts asynchronously; a stalled APB read is abandoned.
- Timeout counter width: $clog2(TIMEOUT_CYCLES). It saturates and never wraps.

Optional Feature:
- Macro: APB_FPU_SEQ_IRQ_EN.
- When defined:
  - irq_o is a level output, set on completion (done or timeout).
  - Cleared by a read of RESULT or by launching a new operation.
  - Set takes priority if both occur in the same cycle.
- When undefined: irq_o is tied 0 and no interrupt flop exists.

Decomposition:
- Package apb_fpu_pkg holds:
  - Register offset localparams (OFFS_OP_A … OFFS_STATUS).
  - FSM state enum typedef.
  - Opsel and flags width constants.
  - STATUS bit index constants.
- Sub-module fpu_seq_timer: a clear/enable saturating counter with a terminal-count output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write OP_A=0x3F800000, OP_B=0x40000000, CTRL=0x1; FPU model returns done after 5 cycles with result 0x40400000, flags 0 -> fpu_start a single pulse at N+1; STATUS reads 0x2; RESULT=0x40400000.
- Issue RESULT read immediately after the CTRL write, with done after 10 cycles -> PREADY low about 10 cycles; read completes with the result and PSLVERR=0.
- FPU model never asserts done, TIMEOUT_CYCLES=64 -> after 64 WAIT cycles STATUS=0x4; stalled RESULT read returns 0 with PSLVERR=1.
- Write OP_A=0x12345678 while busy -> PSLVERR=1; OP_A read after completion returns the prior value; no second fpu_start.
- Read offset 0x14, and write RESULT -> both PSLVERR=1, PREADY=1, no state change.
- Pull RSTN low during WAIT, release, then launch a new operation -> all registers are 0 after reset; the new operation sequences normally. With APB_FPU_SEQ_IRQ_EN, irq_o rises after done and clears on the RESULT read.
